// File: rtl/ddr_rd_return_buf.sv
// DDR read-return buffer: holds read beats from the DDR pipeline and feeds
// the AXI R channel from a registered head. It also keeps a credit count so
// the controller only issues bursts that the buffer has room to return.
// Optional feature macro: DDR_RBUF_OVF_EN (sticky overflow flag on dropped beats).
module ddr_rd_return_buf #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 5,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rstn_async,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  req_valid,
  output logic                  read_accessible,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rlast,
  output logic                  read_respdone,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf
);

  localparam int PW = DEPTH_LOG2 + 1;
  // Credit arithmetic is widened so that a req_len larger than the depth
  // can never wrap and look affordable.
  localparam int CW = ((LEN_W > DEPTH_LOG2) ? LEN_W : DEPTH_LOG2) + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Reset: asserts with rstn_async, releases after two clk edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Two-flop reset release synchroniser.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]     credits_q, credits_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rlast_q, rlast_d;
  logic              respdone_q, respdone_d;
  logic              full, pop, push, rsv;
  logic [CW-1:0]     need, cred_w, cred_next;

  assign full = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign pop  = rvalid_q && rready;
  assign push = in_valid && (!full || pop);

  // Credit check and next-credit computation.
  always_comb begin
    need            = {{(CW-LEN_W){1'b0}}, req_len} + CW'(1);
    cred_w          = {{(CW-PW){1'b0}}, credits_q};
    read_accessible = (cred_w >= need);
    rsv             = req_valid && read_accessible;
    cred_next       = cred_w - (rsv ? need : '0) + (pop ? CW'(1) : '0);
    if (cred_next > DEPTH_C) credits_d = DEPTH_P;
    else                     credits_d = cred_next[PW-1:0];
  end

  // Pointer advance and registered head of the buffer. The head is loaded
  // from the entry rptr_d will point at; when that entry is being written
  // this very cycle, it comes from the incoming beat instead of memory.
  always_comb begin
    wptr_d     = wptr_q + (push ? PW'(1) : '0);
    rptr_d     = rptr_q + (pop  ? PW'(1) : '0);
    rvalid_d   = 1'b0;
    rdata_d    = '0;
    rlast_d    = 1'b0;
    respdone_d = pop && rlast_q;
    if (wptr_d != rptr_d) begin
      rvalid_d = 1'b1;
      if (push && (rptr_d == wptr_q)) begin
        rdata_d = in_data;
        rlast_d = in_last;
      end else begin
        {rlast_d, rdata_d} = mem_q[rptr_d[PW-2:0]];
      end
    end
  end

  // Beat storage; contents are don't-care until covered by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PW-2:0]] <= {in_last, in_data};
  end

  // Control and output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      credits_q  <= DEPTH_P;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      respdone_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      credits_q  <= credits_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
      respdone_q <= respdone_d;
    end
  end

`ifdef DDR_RBUF_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky flag: a beat arrived while full and nothing left.
  always_comb begin
    ovf_d = ovf_q || (in_valid && full && !pop);
  end

  // Overflow flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign rlast         = rlast_q;
  assign read_respdone = respdone_q;
  assign level         = wptr_q - rptr_q;

endmodule

// File: tb/tb_ddr_rd_return_buf.sv
// Bench for ddr_rd_return_buf: scoreboard of expected R beats, checked by a
// negedge monitor whenever the DUT hands a beat over.
module tb_ddr_rd_return_buf;

  localparam int DATA_W = 16;
  localparam int DEPTH_LOG2 = 5;
  localparam int LEN_W = 8;

  logic              clk = 1'b0;
  logic              rstn_async;
  logic [LEN_W-1:0]  req_len;
  logic              req_valid;
  logic              read_accessible;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              read_respdone;
  logic [DEPTH_LOG2:0] level;
  logic              ovf;

  int tests = 0;
  int fails = 0;
  int resp_cnt = 0;
  logic [DATA_W:0] exp_q [$];

  ddr_rd_return_buf #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn_async(rstn_async), .req_len(req_len), .req_valid(req_valid),
    .read_accessible(read_accessible), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rlast(rlast), .read_respdone(read_respdone), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so a handshake seen here fires at the next edge.
  always @(negedge clk) begin
    if (read_respdone) resp_cnt++;
    if (rvalid && rready) begin
      logic [DATA_W:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got data=%h last=%b, required no beat", rdata, rlast);
      end else begin
        e = exp_q.pop_front();
        if ({rlast, rdata} !== e) begin
          fails++;
          $display("FAIL pop_beat: got last=%b data=%h, required last=%b data=%h",
                   rlast, rdata, e[DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn_async = 1'b0;
    req_len = '0; req_valid = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    rready = 1'b0;
    tick(); tick();
    rstn_async = 1'b1;
    tick(); tick(); tick();
    exp_q.delete();
    resp_cnt = 0;
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic l, input bit expect_it);
    in_valid = 1'b1; in_data = d; in_last = l;
    if (expect_it) exp_q.push_back({l, d});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rstn_async = 1'b0;
    req_len = 8'd31; req_valid = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    rready = 1'b0;
    tick();
    tests++;
    if ({rvalid, rdata, rlast, read_respdone, level, ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rvalid=%b rdata=%h rlast=%b respdone=%b level=%0d ovf=%b, required all 0",
               rvalid, rdata, rlast, read_respdone, level, ovf);
    end
    tests++;
    if (read_accessible !== 1'b1) begin
      fails++;
      $display("FAIL reset_credits: got read_accessible(len31)=%b, required 1", read_accessible);
    end
    do_reset();
  endtask

  task automatic test_basic_burst();
    bit ok;
    do_reset();
    rready = 1'b1;
    req_len = 8'd3; #1;
    tests++;
    if (read_accessible !== 1'b1) begin
      fails++; $display("FAIL basic_acc: got %b, required 1", read_accessible);
    end
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    req_len = 8'd31; #1;
    tests++;
    if (read_accessible !== 1'b0) begin
      fails++; $display("FAIL basic_reserved: got acc(len31)=%b, required 0", read_accessible);
    end
    in_valid = 1'b1; in_data = 16'hD000; in_last = 1'b0; #1;
    tests++;
    if (rvalid !== 1'b0) begin
      fails++; $display("FAIL basic_no_bypass: got rvalid=%b, required 0", rvalid);
    end
    exp_q.push_back({1'b0, 16'hD000});
    tick();
    tests++;
    if (rvalid !== 1'b1) begin
      fails++; $display("FAIL basic_rvalid_lat: got rvalid=%b, required 1", rvalid);
    end
    push_beat(16'hD001, 1'b0, 1'b1);
    push_beat(16'hD002, 1'b0, 1'b1);
    push_beat(16'hD003, 1'b1, 1'b1);
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_drain: got %0d beats left, required 0", exp_q.size()); end
    tick(); tick(); tick();
    tests++;
    if (resp_cnt !== 1) begin
      fails++; $display("FAIL basic_respdone: got %0d pulses, required 1", resp_cnt);
    end
    tests++;
    if (read_accessible !== 1'b1 || level !== 0) begin
      fails++; $display("FAIL basic_credits_back: got acc(len31)=%b level=%0d, required 1 and 0",
                        read_accessible, level);
    end
  endtask

  task automatic test_credits();
    do_reset();
    req_len = 8'd15; req_valid = 1'b1;
    tick(); tick();
    req_valid = 1'b0; req_len = 8'd0; #1;
    tests++;
    if (read_accessible !== 1'b0) begin
      fails++; $display("FAIL credits_zero: got acc(len0)=%b, required 0", read_accessible);
    end
    req_valid = 1'b1; tick(); req_valid = 1'b0;
    push_beat(16'h1111, 1'b1, 1'b1);
    tests++;
    if (read_accessible !== 1'b0) begin
      fails++; $display("FAIL credits_ignored_req: got acc(len0)=%b, required 0", read_accessible);
    end
    rready = 1'b1; tick(); rready = 1'b0; #1;
    tests++;
    if (read_accessible !== 1'b1) begin
      fails++; $display("FAIL credits_one_len0: got %b, required 1", read_accessible);
    end
    req_len = 8'd1; #1;
    tests++;
    if (read_accessible !== 1'b0) begin
      fails++; $display("FAIL credits_one_len1: got %b, required 0", read_accessible);
    end
  endtask

  task automatic test_len_bounds();
    logic [LEN_W-1:0] lens [4] = '{8'd32, 8'd31, 8'd255, 8'd0};
    logic             accs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_len = lens[i]; #1;
      tests++;
      if (read_accessible !== accs[i]) begin
        fails++; $display("FAIL len_bound: len=%0d got %b, required %b", lens[i], read_accessible, accs[i]);
      end
    end
  endtask

  task automatic test_hold();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) push_beat(16'hA000 + 16'(i), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (rvalid !== 1'b1 || rdata !== 16'hA000 || level !== 5) begin
        fails++; $display("FAIL hold_stable: cyc %0d got rvalid=%b rdata=%h level=%0d, required 1 a000 5",
                          i, rvalid, rdata, level);
      end
      tick();
    end
    rready = 1'b1;
    push_beat(16'hA005, 1'b1, 1'b1);
    tests++;
    if (level !== 5) begin
      fails++; $display("FAIL hold_push_pop_level: got %0d, required 5", level);
    end
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hold_drain: got %0d left, required 0", exp_q.size()); end
    tick(); tick();
    rready = 1'b0;
  endtask

  task automatic test_overflow();
    bit ok;
    logic exp_ovf;
`ifdef DDR_RBUF_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 32; i++) push_beat(16'hB000 + 16'(i), 1'b0, 1'b1);
    tests++;
    if (level !== 32 || ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_full: got level=%0d ovf=%b, required 32 0", level, ovf);
    end
    push_beat(16'hDEAD, 1'b0, 1'b0);
    tests++;
    if (level !== 32 || ovf !== exp_ovf) begin
      fails++; $display("FAIL ovf_drop: got level=%0d ovf=%b, required 32 %b", level, ovf, exp_ovf);
    end
    rready = 1'b1;
    push_beat(16'hBEEF, 1'b1, 1'b1);
    tests++;
    if (level !== 32) begin
      fails++; $display("FAIL ovf_accept_level: got %0d, required 32", level);
    end
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ovf_drain: got %0d left, required 0", exp_q.size()); end
    tick(); tick();
    rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_len = 8'd8; req_valid = 1'b1; tick(); req_valid = 1'b0;
    for (int i = 0; i < 7; i++) push_beat(16'hC000 + 16'(i), 1'b0, 1'b0);
    #2 rstn_async = 1'b0;
    #1;
    tests++;
    if (rvalid !== 1'b0 || level !== 0) begin
      fails++; $display("FAIL midreset_async: got rvalid=%b level=%0d, required 0 0", rvalid, level);
    end
    tick(); tick();
    rstn_async = 1'b1;
    tick(); tick(); tick();
    req_len = 8'd31; #1;
    tests++;
    if (read_accessible !== 1'b1 || level !== 0 || rvalid !== 1'b0) begin
      fails++; $display("FAIL midreset_release: got acc(len31)=%b level=%0d rvalid=%b, required 1 0 0",
                        read_accessible, level, rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_credits();
    test_len_bounds();
    test_hold();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, required $finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
